// File: rtl/aud_i2s_tx.sv
// I2S-style mono DAC transmitter: sample FIFO, volume/mute on load, serialiser
// slaved to codec-supplied bclk/daclrck that are synchronised into i_clk.
module aud_i2s_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int UNDERRUN_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_aud_bclk,
    input  logic                  i_aud_daclrck,
    input  logic [15:0]           i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_mute,
    input  logic [2:0]            i_vol,
    output logic                  o_aud_dacdat,
    output logic [UNDERRUN_W-1:0] o_underrun_cnt,
    output logic                  o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, SHIFT, HOLD} state_t;

    state_t                state_q, state_d;
    logic                  bclk_s1_q, bclk_s2_q, bclk_h_q;
    logic                  lr_s1_q, lr_s2_q, lr_h_q;
    logic [15:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_q, rd_q;
    logic [CW-1:0]         cnt_q;
    logic [15:0]           sr_q, sr_d;
    logic [15:0]           latch_q, latch_d;
    logic [3:0]            bit_q, bit_d;
    logic                  dac_q, dac_d;
    logic [UNDERRUN_W-1:0] und_q;

    logic        bclk_fall, lr_fall, lr_rise, lr_edge;
    logic        full, empty, push, pop, und_inc, load;
    logic [15:0] sample, ld_val;

    // Edges compare the synchronised level against a one-cycle history.
    assign bclk_fall = bclk_h_q & ~bclk_s2_q;
    assign lr_fall   = lr_h_q & ~lr_s2_q;
    assign lr_rise   = ~lr_h_q & lr_s2_q;
    assign lr_edge   = lr_fall | lr_rise;

    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign o_ready = ~full;
    assign push    = i_valid & ~full;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        latch_d = latch_q;
        bit_d   = bit_q;
        dac_d   = dac_q;
        load    = 1'b0;
        pop     = 1'b0;
        und_inc = 1'b0;
        sample  = latch_q;
        ld_val  = '0;
        case (state_q)
            IDLE: begin
                dac_d = 1'b0;
                if (i_en) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                dac_d = 1'b0;
                if (lr_edge && !i_en) state_d = IDLE;
                else if (lr_fall)     load    = 1'b1;
            end
            default: begin
                if (lr_edge) begin
                    if (!i_en) begin
                        state_d = IDLE;
                        dac_d   = 1'b0;
                    end else begin
                        load = 1'b1;
                    end
                end else if (state_q == SHIFT && bclk_fall) begin
                    if (bit_q == 4'd0) begin
                        state_d = HOLD;
                        dac_d   = 1'b0;
                    end else begin
                        sr_d  = sr_q << 1;
                        dac_d = sr_q[14];
                        bit_d = bit_q - 4'd1;
                    end
                end
            end
        endcase
        // Left loads pop (or starve to zero); right loads replay the latch.
        if (load) begin
            if (lr_fall) begin
                pop     = ~empty;
                und_inc = empty;
                sample  = empty ? 16'h0000 : mem_q[rd_q];
            end
            latch_d = sample;
            ld_val  = i_mute ? 16'h0000 : 16'($signed(sample) >>> i_vol);
            sr_d    = ld_val;
            bit_d   = 4'd15;
            dac_d   = ld_val[15];
            state_d = SHIFT;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_h_q  <= 1'b0;
            lr_s1_q   <= 1'b0;
            lr_s2_q   <= 1'b0;
            lr_h_q    <= 1'b0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            sr_q      <= '0;
            latch_q   <= '0;
            bit_q     <= '0;
            dac_q     <= 1'b0;
            und_q     <= '0;
        end else begin
            state_q   <= state_d;
            bclk_s1_q <= i_aud_bclk;
            bclk_s2_q <= bclk_s1_q;
            bclk_h_q  <= bclk_s2_q;
            lr_s1_q   <= i_aud_daclrck;
            lr_s2_q   <= lr_s1_q;
            lr_h_q    <= lr_s2_q;
            sr_q      <= sr_d;
            latch_q   <= latch_d;
            bit_q     <= bit_d;
            dac_q     <= dac_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (und_inc && und_q != '1) und_q <= und_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_q] <= i_data;
    end

    assign o_aud_dacdat   = dac_q;
    assign o_underrun_cnt = und_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Bench for aud_i2s_tx: directed scenarios plus randomized frames against a
// queue-based model of FIFO, sample latch, volume/mute and underrun count.
module tb_aud_i2s_tx;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, en, bclk, lrck, valid, mute;
    logic [15:0] data;
    logic [2:0]  vol;
    logic        ready, dac, busy;
    logic [7:0]  und;

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    logic [15:0] m_latch;
    int          m_und;
    logic [15:0] w;

    aud_i2s_tx #(.FIFO_DEPTH(DEPTH), .UNDERRUN_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_aud_bclk(bclk), .i_aud_daclrck(lrck),
        .i_data(data), .i_valid(valid), .o_ready(ready),
        .i_mute(mute), .i_vol(vol),
        .o_aud_dacdat(dac), .o_underrun_cnt(und), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] expw(input logic [15:0] s, input logic m, input logic [2:0] v);
        logic signed [15:0] t;
        t = s;
        return m ? 16'h0000 : 16'(t >>> v);
    endfunction

    task automatic push(input logic [15:0] d);
        valid = 1'b1;
        data  = d;
        if (q.size() < DEPTH) q.push_back(d);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // One channel frame: daclrck edge with a bclk fall, then nbits bclk periods,
    // capturing dacdat just before each falling edge. Optional push lands on
    // the load cycle (third clock after the edge is driven).
    task automatic run_frame(input logic lr, input logic pk, input logic [15:0] pd,
                             input int nbits, output logic [15:0] word);
        int sz;
        sz = q.size();
        if (!lr) begin
            if (sz == 0) begin
                m_latch = 16'h0000;
                if (m_und < 255) m_und++;
            end else begin
                m_latch = q.pop_front();
            end
        end
        if (pk && sz < DEPTH) q.push_back(pd);
        lrck = lr;
        bclk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (pk) begin
            valid = 1'b1;
            data  = pd;
        end
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        bclk = 1'b1;
        repeat (8) @(negedge clk);
        word = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            word[15-i] = dac;
            bclk = 1'b0;
            repeat (8) @(negedge clk);
            bclk = 1'b1;
            repeat (8) @(negedge clk);
        end
        if (nbits == 16) chk("hold_zero", {31'd0, dac}, 32'd0);
    endtask

    initial begin
        logic [15:0] smp [5];
        logic        pk, anyhigh;
        logic [15:0] pd;
        int          n;

        rst = 1'b1; en = 1'b0; bclk = 1'b1; lrck = 1'b1;
        valid = 1'b0; data = '0; mute = 1'b0; vol = '0;
        m_latch = '0; m_und = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dac", {31'd0, dac}, 32'd0);
        chk("rst_und", {24'd0, und}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("en_busy", {31'd0, busy}, 32'd1);

        // Basic left/right duplication
        push(16'hA5C3);
        run_frame(1'b0, 1'b0, '0, 16, w);
        chk("a5c3_L", {16'd0, w}, 32'h0000A5C3);
        run_frame(1'b1, 1'b0, '0, 16, w);
        chk("a5c3_R", {16'd0, w}, 32'h0000A5C3);

        // Volume shift sign-extends; mute at load zeros the word
        push(16'h8000);
        vol = 3'd3;
        run_frame(1'b0, 1'b0, '0, 16, w);
        chk("vol3_L", {16'd0, w}, 32'h0000F000);
        mute = 1'b1;
        run_frame(1'b1, 1'b0, '0, 16, w);
        chk("mute_R", {16'd0, w}, 32'h00000000);
        mute = 1'b0; vol = 3'd0;

        // Fill the FIFO, drop the overflow push, drain in order
        for (int i = 0; i < 5; i++) smp[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) push(smp[i]);
        chk("full_ready", {31'd0, ready}, 32'd0);
        push(smp[4]);
        chk("drop_ready", {31'd0, ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b0, 1'b0, '0, 16, w);
            chk("order_L", {16'd0, w}, {16'd0, smp[i]});
            run_frame(1'b1, 1'b0, '0, 16, w);
            chk("order_R", {16'd0, w}, {16'd0, smp[i]});
        end
        chk("drain_ready", {31'd0, ready}, 32'd1);
        chk("drain_und", {24'd0, und}, 32'(m_und));

        // Push coincident with a left load on an empty FIFO
        run_frame(1'b0, 1'b1, 16'h1234, 16, w);
        chk("coinc_word", {16'd0, w}, 32'd0);
        chk("coinc_und", {24'd0, und}, 32'(m_und));
        run_frame(1'b1, 1'b0, '0, 16, w);
        chk("coinc_R", {16'd0, w}, 32'd0);
        run_frame(1'b0, 1'b0, '0, 16, w);
        chk("coinc_next", {16'd0, w}, 32'h00001234);
        run_frame(1'b1, 1'b0, '0, 16, w);

        // Disable: next daclrck edge returns to IDLE, then re-enable
        en = 1'b0;
        lrck = 1'b0;
        bclk = 1'b0;
        repeat (6) @(negedge clk);
        chk("dis_busy", {31'd0, busy}, 32'd0);
        chk("dis_dac", {31'd0, dac}, 32'd0);
        en = 1'b1;
        lrck = 1'b1;
        repeat (6) @(negedge clk);
        chk("reen_busy", {31'd0, busy}, 32'd1);

        // Randomized frames
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) push(16'($urandom));
            vol  = 3'($urandom_range(0, 7));
            mute = ($urandom_range(0, 3) == 0);
            pk   = ($urandom_range(0, 3) == 0);
            pd   = 16'($urandom);
            run_frame(1'b0, pk, pd, 16, w);
            chk("rnd_L", {16'd0, w}, {16'd0, expw(m_latch, mute, vol)});
            vol  = 3'($urandom_range(0, 7));
            mute = ($urandom_range(0, 3) == 0);
            run_frame(1'b1, 1'b0, '0, 16, w);
            chk("rnd_R", {16'd0, w}, {16'd0, expw(m_latch, mute, vol)});
            chk("rnd_und", {24'd0, und}, 32'(m_und));
            chk("rnd_ready", {31'd0, ready}, {31'd0, (q.size() < DEPTH)});
        end
        mute = 1'b0; vol = 3'd0;

        // Reset mid-word at bit 7 with a full FIFO
        while (q.size() < DEPTH) push(16'($urandom));
        run_frame(1'b0, 1'b0, '0, 8, w);
        push(16'($urandom));
        chk("pre_rst_ready", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_dac", {31'd0, dac}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_und", {24'd0, und}, 32'd0);
        rst = 1'b0;
        q.delete();
        m_latch = '0;
        m_und = 0;
        repeat (2) @(negedge clk);

        // Starved left frames saturate the underrun counter
        anyhigh = 1'b0;
        for (int f = 0; f < 300; f++) begin
            lrck = 1'b1;
            for (int c = 0; c < 6; c++) begin @(negedge clk); anyhigh |= dac; end
            lrck = 1'b0;
            if (m_und < 255) m_und++;
            for (int c = 0; c < 6; c++) begin @(negedge clk); anyhigh |= dac; end
        end
        chk("sat_und", {24'd0, und}, 32'(m_und));
        chk("sat_und_max", {24'd0, und}, 32'd255);
        chk("starve_dac", {31'd0, anyhigh}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aud_i2s_tx.md
AUD_I2S_TX -- requirements
Module: aud_i2s_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 16-bit sample entries buffered; power of two, 2..16.
REQ-002 Parameter UNDERRUN_W, default 8, width of the underrun counter.
REQ-003 i_clk  input  1  system clock; the only clock; all logic is rising-edge i_clk.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_en  input  1  playback enable.
REQ-006 i_aud_bclk  input  1  codec bit clock; asynchronous, sampled in i_clk.
REQ-007 i_aud_daclrck  input  1  codec frame clock (0 = left, 1 = right); asynchronous, sampled in i_clk.
REQ-008 i_data  input  16  signed PCM sample from the upstream DSP stage.
REQ-009 i_valid  input  1  i_data valid.
REQ-010 o_ready  output  1  FIFO can accept a sample.
REQ-011 i_mute  input  1  substitute zero for the next loaded sample.
REQ-012 i_vol  input  3  attenuation: arithmetic right shift by 0..7.
REQ-013 o_aud_dacdat  output  1  serial data to codec.
REQ-014 o_underrun_cnt  output  UNDERRUN_W  saturating count of starved left frames.
REQ-015 o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 Input sync: two-flop synchroniser on i_aud_bclk and i_aud_daclrck, then one history register; edges are detected from synchronised value vs. history (3-cycle detect latency).
REQ-017 FIFO: depth FIFO_DEPTH; push when i_valid && o_ready; o_ready = !full (registered count); a push offered while full is dropped and not counted.
REQ-018 FSM states: IDLE, WAIT_FRAME, SHIFT, HOLD.
REQ-019 IDLE -> WAIT_FRAME when i_en = 1; o_aud_dacdat = 0 in IDLE and WAIT_FRAME.
REQ-020 WAIT_FRAME -> SHIFT on the first detected daclrck falling edge (left-channel start); right-channel edges are ignored in this state.
REQ-021 Left load (daclrck falling edge): if FIFO non-empty, pop head into the sample latch; if empty, latch 0 and increment o_underrun_cnt, saturating at 2^UNDERRUN_W-1.
REQ-022 Right load (daclrck rising edge): reuse the latched left sample (mono duplicated); no pop, no underrun count.
REQ-023 Load value = i_mute ? 0 : (sample >>> i_vol), sign-extended, 16 bits, i_mute/i_vol sampled in the load cycle.
REQ-024 In the load cycle, the shift register takes the load value, bit counter = 15, and o_aud_dacdat = bit 15 from the next cycle.
REQ-025 SHIFT: on each detected bclk falling edge, shift left one bit and decrement the counter; after the 16th bit (counter 0 plus one falling edge) go to HOLD, o_aud_dacdat = 0.
REQ-026 HOLD -> SHIFT on the next daclrck edge, with a load per REQ-021/022; a daclrck edge arriving during SHIFT truncates the word and reloads immediately.
REQ-027 Simultaneous push and left-load pop: both take effect; the FIFO count stays unchanged when non-empty. When empty, the pop sees empty, so underrun is counted and the pushed sample is stored.
REQ-028 i_en deasserted: current word finishes, then the FSM enters IDLE at the next daclrck edge; FIFO contents and the counter are retained.
REQ-029 o_aud_dacdat is registered.

Reset
REQ-030 On i_rst = 1: FSM = IDLE, FIFO empty, o_ready = 1, o_aud_dacdat = 0, o_underrun_cnt = 0, o_busy = 0, shift register, latch and sync flops = 0; this takes effect in the same cycle even mid-word.

Verification
REQ-031 Push 16'hA5C3, i_vol = 0, i_en = 1, drive a left frame -> dacdat bits 1010_0101_1100_0011 MSB first on successive bclk falling edges; right frame repeats A5C3.
REQ-032 Push 16'h8000, i_vol = 3 -> serial word 16'hF000; i_mute = 1 at load -> 16'h0000.
REQ-033 Push 4 samples with no frames -> o_ready = 0; a fifth push is dropped; four left frames then emit the 4 samples in order.
REQ-034 Empty FIFO across 300 left frames -> o_underrun_cnt = 255 (saturated), dacdat all zero.
REQ-035 Assert i_rst at bit 7 of a word -> next cycle dacdat = 0, state IDLE, o_ready = 1, count = 0.
REQ-036 Push coincident with a left load on an empty FIFO -> underrun +1, zero word emitted, the pushed sample plays on the next left frame.
